tx_iq_dac_pacer: RTL and testbench

TX_IQ_DAC_PACER -- requirements
Module: tx_iq_dac_pacer

---
 rtl/tx_intf_pkg.sv | 18 +
 rtl/tx_tick_gen.sv | 21 ++
 rtl/tx_iq_dac_pacer.sv | 152 +++++++++++++++
 tb/tb_tx_iq_dac_pacer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_intf_pkg.sv
// Shared types and defaults for the transmit I/Q pacing path.
package tx_intf_pkg;

  localparam int RAMP_SHIFT_MAX_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP_UP,
    ST_ACTIVE,
    ST_RAMP_DOWN
  } tx_state_e;

  // Limit the requested ramp exponent to what the gain counter can represent.
  function automatic logic [2:0] clamp_shift(input logic [2:0] req, input int max_shift);
    return (int'(req) > max_shift) ? 3'(max_shift) : req;
  endfunction

endpackage

// File: rtl/tx_tick_gen.sv
// Sample-rate tick: fires every rate_div+1 clocks; rate_div is sampled only on reload.
module tx_tick_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rate_div,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == 8'd0);
    cnt_d = tick ? rate_div : cnt_q - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_iq_dac_pacer.sv
// Paces I/Q samples from an upstream FIFO to the DAC at a programmable rate,
// applying a linear gain ramp at burst start and end to avoid spectral splatter.
module tx_iq_dac_pacer
  import tx_intf_pkg::*;
#(
  parameter int IQ_DATA_WIDTH  = 16,
  parameter int RAMP_SHIFT_MAX = RAMP_SHIFT_MAX_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*IQ_DATA_WIDTH-1:0] iq_pack,
  input  logic                       iq_fifo_empty,
  output logic                       iq_ready,
  input  logic                       enable,
  input  logic [7:0]                 rate_div,
  input  logic [2:0]                 ramp_shift,
  output logic [IQ_DATA_WIDTH-1:0]   dac_i,
  output logic [IQ_DATA_WIDTH-1:0]   dac_q,
  output logic                       dac_valid,
  output logic                       tx_active,
  output logic [15:0]                burst_samples
);

  localparam int W  = IQ_DATA_WIDTH;
  localparam int KW = RAMP_SHIFT_MAX + 1;
  localparam int PW = W + KW + 1;

  tx_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [2:0] shift_q, shift_d;
  logic signed [W-1:0] hold_i_q, hold_i_d, hold_q_q, hold_q_d;
  logic signed [W-1:0] dac_i_q, dac_i_d, dac_q_q, dac_q_d;
  logic dac_valid_q, dac_valid_d;
  logic [15:0] burst_q, burst_d;

  logic tick;
  logic have_data;
  logic pop;
  logic clear_burst;
  logic [KW-1:0] k_full, k_dn;
  tx_state_e dn_state;
  logic signed [W-1:0] src_i, src_q;
  logic signed [PW-1:0] prod_i, prod_q;

  tx_tick_gen u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .rate_div (rate_div),
    .tick     (tick)
  );

  // Next-state, gain and pop decisions; nothing moves except on a tick.
  always_comb begin
    have_data   = enable && !iq_fifo_empty;
    k_full      = KW'(1) << shift_q;
    k_dn        = (k_q == '0) ? '0 : k_q - KW'(1);
    dn_state    = (k_dn == '0) ? ST_IDLE : ST_RAMP_DOWN;
    state_d     = state_q;
    k_d         = k_q;
    shift_d     = shift_q;
    pop         = 1'b0;
    clear_burst = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (have_data) begin
            state_d     = ST_RAMP_UP;
            k_d         = '0;
            shift_d     = clamp_shift(ramp_shift, RAMP_SHIFT_MAX);
            clear_burst = 1'b1;
          end
        end
        ST_RAMP_UP: begin
          if (have_data) begin
            pop = 1'b1;
            k_d = k_q + KW'(1);
            if (k_d == k_full) state_d = ST_ACTIVE;
          end else begin
            k_d     = k_dn;
            state_d = dn_state;
          end
        end
        ST_ACTIVE: begin
          if (have_data) begin
            pop = 1'b1;
          end else begin
            k_d     = k_dn;
            state_d = dn_state;
          end
        end
        ST_RAMP_DOWN: begin
          // A refill resumes the up-ramp from the present gain, so no step.
          if (have_data) begin
            state_d = ST_RAMP_UP;
          end else begin
            k_d     = k_dn;
            state_d = dn_state;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Gain shaping: signed sample times unsigned gain, floor-divided by 2^shift.
  always_comb begin
    src_i    = pop ? iq_pack[W-1:0]   : hold_i_q;
    src_q    = pop ? iq_pack[2*W-1:W] : hold_q_q;
    hold_i_d = clear_burst ? '0 : src_i;
    hold_q_d = clear_burst ? '0 : src_q;
    prod_i   = $signed(PW'(src_i)) * $signed(PW'({1'b0, k_d}));
    prod_q   = $signed(PW'(src_q)) * $signed(PW'({1'b0, k_d}));
    dac_i_d     = tick ? W'(prod_i >>> shift_q) : dac_i_q;
    dac_q_d     = tick ? W'(prod_q >>> shift_q) : dac_q_q;
    dac_valid_d = tick;
    if (clear_burst)                    burst_d = 16'd0;
    else if (pop && burst_q != 16'hFFFF) burst_d = burst_q + 16'd1;
    else                                 burst_d = burst_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      shift_q     <= 3'd0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      dac_i_q     <= '0;
      dac_q_q     <= '0;
      dac_valid_q <= 1'b0;
      burst_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      shift_q     <= shift_d;
      hold_i_q    <= hold_i_d;
      hold_q_q    <= hold_q_d;
      dac_i_q     <= dac_i_d;
      dac_q_q     <= dac_q_d;
      dac_valid_q <= dac_valid_d;
      burst_q     <= burst_d;
    end
  end

  assign iq_ready      = pop;
  assign dac_i         = dac_i_q;
  assign dac_q         = dac_q_q;
  assign dac_valid     = dac_valid_q;
  assign tx_active     = (state_q != ST_IDLE);
  assign burst_samples = burst_q;

endmodule

// File: tb/tb_tx_iq_dac_pacer.sv
// Self-checking bench for tx_iq_dac_pacer: vector table of bursts plus refill and reset sequences.
`timescale 1ns/1ps
module tb_tx_iq_dac_pacer;

  localparam int W   = 16;
  localparam int RSM = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iq_pack;
  logic        iq_fifo_empty;
  logic        iq_ready;
  logic        enable = 1'b0;
  logic [7:0]  rate_div = 8'd0;
  logic [2:0]  ramp_shift = 3'd0;
  logic [15:0] dac_i, dac_q, burst_samples;
  logic        dac_valid, tx_active;

  int checks = 0;
  int failures = 0;

  logic [31:0] srcMem [0:255];
  int   srcRd = 0;
  int   srcWr = 0;
  logic flushReq = 1'b0;
  logic popReq = 1'b0;
  logic monOn = 1'b0;
  int   popCount = 0;
  int   curRate = 0;
  int   m = 0;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } expT;
  expT expQ[$];

  typedef struct {
    int rateDiv;
    int rampShift;
    int nSamples;
    int sampI;
    int sampQ;
    int expTicks;
  } vecT;
  vecT vecs[6];

  tx_iq_dac_pacer #(.IQ_DATA_WIDTH(W), .RAMP_SHIFT_MAX(RSM)) dut (
    .clk           (clk),
    .rst           (rst),
    .iq_pack       (iq_pack),
    .iq_fifo_empty (iq_fifo_empty),
    .iq_ready      (iq_ready),
    .enable        (enable),
    .rate_div      (rate_div),
    .ramp_shift    (ramp_shift),
    .dac_i         (dac_i),
    .dac_q         (dac_q),
    .dac_valid     (dac_valid),
    .tx_active     (tx_active),
    .burst_samples (burst_samples)
  );

  always #5 clk = ~clk;

  assign iq_fifo_empty = (srcRd == srcWr);
  assign iq_pack       = iq_fifo_empty ? 32'd0 : srcMem[srcRd & 255];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int floorShift(input int a, input int sh);
    int d;
    int r;
    d = 1 << sh;
    r = a / d;
    if ((a % d) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  function automatic expT mkExp(input int vi, input int vq);
    expT e;
    e.i = 16'(vi);
    e.q = 16'(vq);
    return e;
  endfunction

  // Upstream FIFO model: consume the head one step after a sampled pop strobe.
  always @(posedge clk) begin
    #1;
    if (flushReq) srcRd = srcWr;
    else if (popReq && !rst) begin
      srcRd++;
      popCount++;
    end
  end

  // Monitor: strobe cadence, pop legality and scoreboard comparison.
  always @(negedge clk) begin
    expT e;
    popReq = iq_ready;
    if (iq_fifo_empty) checkOutput("iq_ready_while_empty", iq_ready, 0);
    if (!monOn) m = 0;
    else begin
      checkOutput("dac_valid_cadence", dac_valid, (m % (curRate + 1)) == 0);
      if (iq_ready) checkOutput("iq_ready_phase", (m + 1) % (curRate + 1), 0);
      if (dac_valid && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("dac_i", dac_i, e.i);
        checkOutput("dac_q", dac_q, e.q);
      end
      m++;
    end
  end

  task automatic flushFifo();
    flushReq = 1'b1;
    @(posedge clk);
    #2;
    flushReq = 1'b0;
  endtask

  task automatic pushSample(input int vi, input int vq);
    srcMem[srcWr & 255] = {16'(vq), 16'(vi)};
    srcWr++;
  endtask

  task automatic applyStimulus(input vecT v);
    int rsEff;
    int full;
    int g;
    int kN;
    int startPops;
    monOn = 1'b0;
    rst = 1'b1;
    enable = 1'b1;
    rate_div = 8'(v.rateDiv);
    ramp_shift = 3'(v.rampShift);
    curRate = v.rateDiv;
    flushFifo();
    expQ.delete();
    for (int n = 0; n < v.nSamples; n++) pushSample(v.sampI, v.sampQ);
    rsEff = (v.rampShift > RSM) ? RSM : v.rampShift;
    full = 1 << rsEff;
    kN = (v.nSamples < full) ? v.nSamples : full;
    expQ.push_back(mkExp(0, 0));
    for (int j = 1; j <= v.nSamples; j++) begin
      g = (j < full) ? j : full;
      expQ.push_back(mkExp(floorShift(v.sampI * g, rsEff), floorShift(v.sampQ * g, rsEff)));
    end
    for (int k = kN - 1; k >= 0; k--)
      expQ.push_back(mkExp(floorShift(v.sampI * k, rsEff), floorShift(v.sampQ * k, rsEff)));
    expQ.push_back(mkExp(0, 0));
    expQ.push_back(mkExp(0, 0));
    startPops = popCount;
    @(negedge clk);
    #1;
    rst = 1'b0;
    monOn = 1'b1;
    repeat (3) @(negedge clk);
    ramp_shift = 3'((v.rampShift + 1) % 8);
    repeat ((v.expTicks + 2) * (v.rateDiv + 1) + 2) @(negedge clk);
    #1;
    monOn = 1'b0;
    checkOutput("scoreboard_drained", expQ.size(), 0);
    expQ.delete();
    checkOutput("pop_count", popCount - startPops, v.nSamples);
    checkOutput("burst_samples", burst_samples, v.nSamples);
    checkOutput("tx_active_after_burst", tx_active, 0);
  endtask

  // Refill at k=2 during the down-ramp: gain resumes from 2 then climbs to 3.
  task automatic refillSequence();
    monOn = 1'b0;
    rst = 1'b1;
    enable = 1'b1;
    rate_div = 8'd1;
    ramp_shift = 3'd2;
    curRate = 1;
    flushFifo();
    expQ.delete();
    for (int n = 0; n < 5; n++) pushSample('h4000, 'h0400);
    expQ.push_back(mkExp(0, 0));
    expQ.push_back(mkExp('h1000, 'h100));
    expQ.push_back(mkExp('h2000, 'h200));
    expQ.push_back(mkExp('h3000, 'h300));
    expQ.push_back(mkExp('h4000, 'h400));
    expQ.push_back(mkExp('h4000, 'h400));
    expQ.push_back(mkExp('h3000, 'h300));
    expQ.push_back(mkExp('h2000, 'h200));
    expQ.push_back(mkExp('h2000, 'h200));
    expQ.push_back(mkExp(-'h1800, 'hC));
    expQ.push_back(mkExp(-'h1000, 'h8));
    expQ.push_back(mkExp(-'h0800, 'h4));
    expQ.push_back(mkExp(0, 0));
    expQ.push_back(mkExp(0, 0));
    expQ.push_back(mkExp(0, 0));
    @(negedge clk);
    #1;
    rst = 1'b0;
    monOn = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("refill_active_in_rampdown", tx_active, 1);
    #1;
    pushSample(-'h2000, 'h0010);
    repeat (20) @(negedge clk);
    #1;
    monOn = 1'b0;
    checkOutput("refill_scoreboard_drained", expQ.size(), 0);
    expQ.delete();
    checkOutput("refill_burst_samples", burst_samples, 6);
    checkOutput("refill_tx_active_end", tx_active, 0);
  endtask

  // Asynchronous reset in the middle of an active burst at full rate.
  task automatic resetSequence();
    int snapPops;
    monOn = 1'b0;
    rst = 1'b1;
    enable = 1'b1;
    rate_div = 8'd0;
    ramp_shift = 3'd1;
    curRate = 0;
    flushFifo();
    for (int n = 0; n < 20; n++) pushSample('h1000, -'h1000);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("pre_reset_tx_active", tx_active, 1);
    checkOutput("pre_reset_burst", burst_samples, 5);
    checkOutput("pre_reset_dac_i", dac_i, 'h1000);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("reset_dac_i", dac_i, 0);
    checkOutput("reset_dac_q", dac_q, 0);
    checkOutput("reset_dac_valid", dac_valid, 0);
    checkOutput("reset_iq_ready", iq_ready, 0);
    checkOutput("reset_burst", burst_samples, 0);
    checkOutput("reset_tx_active", tx_active, 0);
    @(posedge clk);
    #2;
    snapPops = popCount;
    repeat (3) begin
      @(negedge clk);
      checkOutput("iq_ready_in_reset", iq_ready, 0);
    end
    enable = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("post_release_iq_ready", iq_ready, 0);
    @(negedge clk);
    checkOutput("post_release_dac_valid", dac_valid, 1);
    checkOutput("post_release_dac_i", dac_i, 0);
    checkOutput("post_release_tx_active", tx_active, 0);
    checkOutput("no_pops_after_reset", popCount - snapPops, 0);
    rst = 1'b1;
    flushFifo();
  endtask

  initial begin
    //            rate rs  n   I         Q        ticks
    vecs[0] = '{4, 2, 10, 'h4000,  -5,       15};
    vecs[1] = '{0, 2, 6,  -'h4000, 5,        11};
    vecs[2] = '{1, 0, 3,  'h1234,  -'h0101,  5};
    vecs[3] = '{2, 7, 3,  'h7fff,  -'h8000,  7};
    vecs[4] = '{0, 3, 0,  'h1111,  'h2222,   1};
    vecs[5] = '{3, 1, 5,  -3,      7,        8};

    repeat (3) @(negedge clk);
    checkOutput("init_dac_valid", dac_valid, 0);
    checkOutput("init_tx_active", tx_active, 0);
    checkOutput("init_burst", burst_samples, 0);
    checkOutput("init_iq_ready", iq_ready, 0);
    checkOutput("init_dac_i", dac_i, 0);

    for (int t = 0; t < 6; t++) applyStimulus(vecs[t]);
    refillSequence();
    resetSequence();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
